// File: rtl/irq_if.sv
// Core/source-side signal bundle of the interrupt controller.
// slave = controller side, master = CPU/source side driving the requests.
interface irq_if #(
  parameter int NUM_SRC = 4
);
  logic [NUM_SRC-1:0] src_req;
  logic [NUM_SRC-1:0] src_ack;
  logic               global_en;
  logic               mask_we;
  logic [NUM_SRC-1:0] mask_in;
  logic [NUM_SRC-1:0] mask_out;
  logic               irq;
  logic               int_ack;
  logic [7:0]         vector;
  logic               eoi;
  logic               in_service;
  logic [1:0]         dbg_state;

  modport slave (
    input  src_req, global_en, mask_we, mask_in, int_ack, eoi,
    output src_ack, mask_out, irq, vector, in_service, dbg_state
  );

  modport master (
    output src_req, global_en, mask_we, mask_in, int_ack, eoi,
    input  src_ack, mask_out, irq, vector, in_service, dbg_state
  );
endinterface

// File: rtl/irq_controller.sv
// Fixed-priority interrupt controller with req/ack/eoi handshake to the core.
// Define IRQC_EDGE_EN for sticky rising-edge capture; default is level mode.
//
// Handshake: irq is held in REQ until the core raises int_ack (sampled only in
// REQ); one ACK cycle pulses src_ack[idx]; in_service holds until eoi (sampled
// only in SERVICE). dbg_state exposes the FSM state.
module irq_controller #(
  parameter int         NUM_SRC       = 4,
  parameter logic [7:0] VECTOR_BASE   = 8'h08,
  parameter logic [7:0] VECTOR_STRIDE = 8'h04
) (
  input  logic   clk,
  input  logic   rst,
  irq_if.slave   bus
);
  localparam int IDXW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_REQ     = 2'd1;
  localparam logic [1:0] S_ACK     = 2'd2;
  localparam logic [1:0] S_SERVICE = 2'd3;

  logic [1:0]         state;
  logic [NUM_SRC-1:0] mask;
  logic [NUM_SRC-1:0] pend;
  logic [NUM_SRC-1:0] elig;
  logic [IDXW-1:0]    idx;
  logic [IDXW-1:0]    first_idx;
  logic [7:0]         vector_q;

  assign elig = pend & ~mask;

  // Descending scan so the lowest set index is the final assignment.
  always_comb begin
    first_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (elig[i]) first_idx = IDXW'(i);
    end
  end

  assign bus.src_ack    = (state == S_ACK) ? (NUM_SRC'(1) << idx) : '0;
  assign bus.irq        = (state == S_REQ);
  assign bus.in_service = (state == S_SERVICE);
  assign bus.vector     = vector_q;
  assign bus.mask_out   = mask;
  assign bus.dbg_state  = state;

`ifdef IRQC_EDGE_EN
  logic [NUM_SRC-1:0] prev;
  logic [NUM_SRC-1:0] rise;

  assign rise = bus.src_req & ~prev;

  // A new edge in the ACK cycle survives the clear because the OR is applied last.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev <= '0;
      pend <= '0;
    end else begin
      prev <= bus.src_req;
      pend <= (pend & ~bus.src_ack) | rise;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) pend <= '0;
    else     pend <= bus.src_req;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      mask     <= '1;
      idx      <= '0;
      vector_q <= 8'h00;
    end else begin
      if (bus.mask_we) mask <= bus.mask_in;
      case (state)
        S_IDLE: begin
          if (bus.global_en && (elig != '0)) begin
            idx      <= first_idx;
            vector_q <= VECTOR_BASE + 8'(first_idx) * VECTOR_STRIDE;
            state    <= S_REQ;
          end
        end
        // Once latched, masking or a dropped source does not withdraw the request.
        S_REQ: begin
          if (bus.int_ack)         state <= S_ACK;
          else if (!bus.global_en) state <= S_IDLE;
        end
        S_ACK:     state <= S_SERVICE;
        S_SERVICE: if (bus.eoi) state <= S_IDLE;
        default:   state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller; covers level mode and, when
// IRQC_EDGE_EN is defined, the sticky edge-capture scenario.
module tb_irq_controller;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests_run = 0;
  int   tests_failed = 0;

  irq_if #(.NUM_SRC(4)) bus ();

  irq_controller #(.NUM_SRC(4), .VECTOR_BASE(8'h08), .VECTOR_STRIDE(8'h04)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Each step lands 1 ns after a rising edge: inputs change and outputs are read there.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // src_ack must be one-hot or zero on every cycle.
  always @(negedge clk) begin
    if (!rst) begin
      tests_run++;
      if ($countones(bus.src_ack) > 1) begin
        tests_failed++;
        $display("FAIL src_ack_onehot: got %b, required at most one bit set", bus.src_ack);
      end
    end
  end

  task automatic write_mask(input logic [3:0] m);
    bus.mask_we = 1'b1;
    bus.mask_in = m;
    tick();
    bus.mask_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tests_run++;
    if (bus.irq !== 1'b0 || bus.src_ack !== 4'b0000 || bus.vector !== 8'h00 ||
        bus.in_service !== 1'b0 || bus.mask_out !== 4'b1111) begin
      tests_failed++;
      $display("FAIL reset_values: irq=%b src_ack=%b vector=%h in_service=%b mask=%b, required 0 0000 00 0 1111",
               bus.irq, bus.src_ack, bus.vector, bus.in_service, bus.mask_out);
    end
  endtask

  task automatic test_single();
    bus.global_en = 1'b1;
    write_mask(4'b0000);
    tests_run++;
    if (bus.mask_out !== 4'b0000) begin
      tests_failed++;
      $display("FAIL mask_write: got %b, required 0000", bus.mask_out);
    end
    bus.src_req = 4'b0100;
    tick();
    tests_run++;
    if (bus.irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_irq_early: got %b, required 0", bus.irq);
    end
    tick();
    tests_run++;
    if (bus.irq !== 1'b1 || bus.vector !== 8'h10) begin
      tests_failed++;
      $display("FAIL single_irq: irq=%b vector=%h, required 1 10", bus.irq, bus.vector);
    end
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
    tests_run++;
    if (bus.src_ack !== 4'b0100 || bus.irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_ack: src_ack=%b irq=%b, required 0100 0", bus.src_ack, bus.irq);
    end
    bus.src_req = 4'b0000;
    tick();
    tests_run++;
    if (bus.src_ack !== 4'b0000 || bus.in_service !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_service: src_ack=%b in_service=%b, required 0000 1", bus.src_ack, bus.in_service);
    end
    bus.eoi = 1'b1;
    tick();
    bus.eoi = 1'b0;
    tick();
    tick();
    tests_run++;
    if (bus.in_service !== 1'b0 || bus.irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_eoi: in_service=%b irq=%b, required 0 0", bus.in_service, bus.irq);
    end
  endtask

  task automatic test_priority();
    bus.src_req = 4'b1010;
    tick();
    tick();
    tests_run++;
    if (bus.irq !== 1'b1 || bus.vector !== 8'h0C) begin
      tests_failed++;
      $display("FAIL prio_first: irq=%b vector=%h, required 1 0c", bus.irq, bus.vector);
    end
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
    tests_run++;
    if (bus.src_ack !== 4'b0010) begin
      tests_failed++;
      $display("FAIL prio_ack_first: got %b, required 0010", bus.src_ack);
    end
    bus.src_req = 4'b1000;
    tick();
    bus.eoi = 1'b1;
    tick();
    bus.eoi = 1'b0;
    tests_run++;
    if (bus.irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL prio_idle_gap: irq=%b, required 0", bus.irq);
    end
    tick();
    tests_run++;
    if (bus.irq !== 1'b1 || bus.vector !== 8'h14) begin
      tests_failed++;
      $display("FAIL prio_second: irq=%b vector=%h, required 1 14", bus.irq, bus.vector);
    end
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
    tests_run++;
    if (bus.src_ack !== 4'b1000) begin
      tests_failed++;
      $display("FAIL prio_ack_second: got %b, required 1000", bus.src_ack);
    end
    bus.src_req = 4'b0000;
    tick();
    bus.eoi = 1'b1;
    tick();
    bus.eoi = 1'b0;
    tick();
  endtask

  task automatic test_mask_and_enable();
    int seen;
    write_mask(4'b0001);
    bus.src_req = 4'b0001;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.irq !== 1'b0) seen++;
    end
    tests_run++;
    if (seen != 0) begin
      tests_failed++;
      $display("FAIL masked_irq: irq high on %0d cycles, required 0", seen);
    end
    write_mask(4'b0000);
    tests_run++;
    if (bus.irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL unmask_early: irq=%b, required 0", bus.irq);
    end
    tick();
    tests_run++;
    if (bus.irq !== 1'b1 || bus.vector !== 8'h08) begin
      tests_failed++;
      $display("FAIL unmask_irq: irq=%b vector=%h, required 1 08", bus.irq, bus.vector);
    end
    bus.global_en = 1'b0;
    tick();
    tests_run++;
    if (bus.irq !== 1'b0 || bus.src_ack !== 4'b0000) begin
      tests_failed++;
      $display("FAIL gen_drop: irq=%b src_ack=%b, required 0 0000", bus.irq, bus.src_ack);
    end
    tick();
    tests_run++;
    if (bus.irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL gen_low_hold: irq=%b, required 0", bus.irq);
    end
    bus.global_en = 1'b1;
    tick();
    tests_run++;
    if (bus.irq !== 1'b1 || bus.vector !== 8'h08) begin
      tests_failed++;
      $display("FAIL gen_rearm: irq=%b vector=%h, required 1 08", bus.irq, bus.vector);
    end
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
    tests_run++;
    if (bus.src_ack !== 4'b0001) begin
      tests_failed++;
      $display("FAIL gen_ack: got %b, required 0001", bus.src_ack);
    end
    bus.src_req = 4'b0000;
    tick();
    bus.eoi = 1'b1;
    tick();
    bus.eoi = 1'b0;
    tick();
  endtask

  task automatic test_reset_in_service();
    bus.src_req = 4'b0100;
    tick();
    tick();
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
    bus.src_req = 4'b0000;
    tick();
    tests_run++;
    if (bus.in_service !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_pre_service: in_service=%b, required 1", bus.in_service);
    end
    rst = 1'b1;
    tick();
    tests_run++;
    if (bus.in_service !== 1'b0 || bus.mask_out !== 4'b1111 || bus.src_ack !== 4'b0000 || bus.irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_mid: in_service=%b mask=%b src_ack=%b irq=%b, required 0 1111 0000 0",
               bus.in_service, bus.mask_out, bus.src_ack, bus.irq);
    end
    rst = 1'b0;
    tick();
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
    bus.eoi = 1'b1;
    tick();
    bus.eoi = 1'b0;
    tests_run++;
    if (bus.irq !== 1'b0 || bus.src_ack !== 4'b0000 || bus.in_service !== 1'b0 || bus.dbg_state !== 2'd0) begin
      tests_failed++;
      $display("FAIL idle_ignore: irq=%b src_ack=%b in_service=%b state=%0d, required 0 0000 0 0",
               bus.irq, bus.src_ack, bus.in_service, bus.dbg_state);
    end
  endtask

`ifdef IRQC_EDGE_EN
  task automatic test_edge();
    write_mask(4'b0000);
    bus.src_req = 4'b0010;
    tick();
    bus.src_req = 4'b0000;
    tick();
    tests_run++;
    if (bus.irq !== 1'b1 || bus.vector !== 8'h0C) begin
      tests_failed++;
      $display("FAIL edge_irq: irq=%b vector=%h, required 1 0c", bus.irq, bus.vector);
    end
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
    tests_run++;
    if (bus.src_ack !== 4'b0010) begin
      tests_failed++;
      $display("FAIL edge_ack: got %b, required 0010", bus.src_ack);
    end
    bus.src_req = 4'b0010;
    tick();
    bus.src_req = 4'b0000;
    bus.eoi = 1'b1;
    tick();
    bus.eoi = 1'b0;
    tests_run++;
    if (bus.irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL edge_gap: irq=%b, required 0", bus.irq);
    end
    tick();
    tests_run++;
    if (bus.irq !== 1'b1 || bus.vector !== 8'h0C) begin
      tests_failed++;
      $display("FAIL edge_retained: irq=%b vector=%h, required 1 0c", bus.irq, bus.vector);
    end
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
    tick();
    bus.eoi = 1'b1;
    tick();
    bus.eoi = 1'b0;
    tick();
  endtask
`endif

  initial begin
    bus.src_req   = 4'b0000;
    bus.global_en = 1'b0;
    bus.mask_we   = 1'b0;
    bus.mask_in   = 4'b0000;
    bus.int_ack   = 1'b0;
    bus.eoi       = 1'b0;
    #1;
    test_reset();
    test_single();
    test_priority();
    test_mask_and_enable();
    test_reset_in_service();
`ifdef IRQC_EDGE_EN
    test_edge();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
